// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture block: frame geometry defaults and FSM encoding.
package cam_pkg;

  localparam int unsigned H_ACTIVE_DEFAULT = 640;
  localparam int unsigned V_ACTIVE_DEFAULT = 480;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitVs = 2'd1,
    StActive = 2'd2
  } cam_state_e;

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer for one asynchronous camera control pin, with rise/fall detect
// on the synchronized value.
module cam_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q    = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/cam_capture.sv
// DVP camera capture: assembles RGB565 pixels from byte pairs into a ready/valid stream.
// Define CAM_CAPTURE_FRAME_CNT_EN to add a 16-bit wrapping frame counter output.
module cam_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_d,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic        ovf,
  output logic        line_err,
  input  logic        err_clr
`ifdef CAM_CAPTURE_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  // One spare count above V_ACTIVE so frames with too many lines are still caught.
  localparam int unsigned YW = $clog2(V_ACTIVE + 2);
  localparam logic [XW-1:0] XMax  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] XLast = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YFull = YW'(V_ACTIVE);
  localparam logic [YW-1:0] YSat  = YW'(V_ACTIVE + 1);

  logic pclk_s, pclk_rise, pclk_fall;
  logic vs_s, vs_rise, vs_fall;
  logic href_s, href_rise, href_fall;

  cam_sync u_sync_pclk (
    .clk  (clk),
    .rst  (rst),
    .d    (cam_pclk),
    .q    (pclk_s),
    .rise (pclk_rise),
    .fall (pclk_fall)
  );

  cam_sync u_sync_vsync (
    .clk  (clk),
    .rst  (rst),
    .d    (cam_vsync),
    .q    (vs_s),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  cam_sync u_sync_href (
    .clk  (clk),
    .rst  (rst),
    .d    (cam_href),
    .q    (href_s),
    .rise (href_rise),
    .fall (href_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{pclk_s, pclk_fall, vs_s, href_rise};

  // Data bus shares the pclk synchronizer latency so each sample event sees its own byte.
  logic [7:0] d_meta_q, d_sync_q;

  cam_state_e state_q, state_d;
  logic       cnt_clr, frame_end;

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && vs_rise) state_d = StWaitVs;
      end
      StWaitVs: begin
        if (vs_fall) begin
          state_d = StActive;
          cnt_clr = 1'b1;
        end
      end
      StActive: begin
        if (vs_rise) begin
          frame_end = 1'b1;
          state_d   = en ? StWaitVs : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic          phase_q;
  logic [7:0]    hi_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [15:0]   pix_data_q;
  logic          pix_valid_q, pix_sof_q, pix_eol_q;
  logic          frame_done_q, ovf_q, line_err_q;

  logic active, sample, complete, line_end, accept, load, drop, line_err_set;

  always_comb begin
    active       = (state_q == StActive);
    sample       = active & pclk_rise & href_s;
    complete     = sample & phase_q;
    line_end     = active & href_fall;
    accept       = pix_valid_q & pix_ready;
    load         = complete & (~pix_valid_q | accept);
    drop         = complete & ~load;
    line_err_set = (line_end && (x_q != XMax)) || (frame_end && (y_q != YFull));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_meta_q     <= '0;
      d_sync_q     <= '0;
      state_q      <= StIdle;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_sof_q    <= 1'b0;
      pix_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      d_meta_q     <= cam_d;
      d_sync_q     <= d_meta_q;
      state_q      <= state_d;
      frame_done_q <= frame_end;

      if (!href_s || !active) begin
        phase_q <= 1'b0;
      end else if (sample) begin
        phase_q <= ~phase_q;
      end

      if (sample && !phase_q) hi_q <= d_sync_q;

      if (cnt_clr) begin
        x_q <= '0;
        y_q <= '0;
      end else if (line_end) begin
        x_q <= '0;
        if (y_q != YSat) y_q <= y_q + YW'(1);
      end else if (complete && (x_q != XMax)) begin
        x_q <= x_q + XW'(1);
      end

      if (load) begin
        pix_data_q  <= {hi_q, d_sync_q};
        pix_sof_q   <= (x_q == '0) && (y_q == '0);
        pix_eol_q   <= (x_q == XLast);
        pix_valid_q <= 1'b1;
      end else if (accept) begin
        pix_valid_q <= 1'b0;
      end

      if (drop) begin
        ovf_q <= 1'b1;
      end else if (err_clr) begin
        ovf_q <= 1'b0;
      end

      if (line_err_set) begin
        line_err_q <= 1'b1;
      end else if (err_clr) begin
        line_err_q <= 1'b0;
      end
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign pix_sof    = pix_sof_q;
  assign pix_eol    = pix_eol_q;
  assign frame_done = frame_done_q;
  assign ovf        = ovf_q;
  assign line_err   = line_err_q;

`ifdef CAM_CAPTURE_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_end) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
